i2s_playback_ctrl: RTL
======================

Name: i2s_playback_ctrl

Overview:
Playback sequencer sitting between the on-chip sample RAM and the 24-bit I2S transmitter. On command it walks a programmable window of RAM (base, length, optional loop) and prefetches samples into a 2-entry buffer. It drives the transmitter's valid/ready sample handshake and its buffer-ready start qualifier, then drains and reports completion.

Parameters:
DATA_W, 24, sample width; matches the transmitter sample port
ADDR_W, 10, sample RAM address width
CNT_W, 16, width of the accepted-sample counter

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle start command
stop_i  in  1  one-cycle abort command
loop_i  in  1  loop mode, sampled on accepted start
base_addr_i  in  ADDR_W  first RAM address, sampled on start
length_i  in  ADDR_W+1  number of samples in window, sampled on start
rd_en_o  out  1  RAM read strobe
rd_addr_o  out  ADDR_W  RAM read address
rd_data_i  in  DATA_W  RAM read data, valid exactly 1 cycle after rd_en_o
tx_data_o  out  DATA_W  sample to transmitter (signed)
tx_valid_o  out  1  sample valid to transmitter
tx_ready_i  in  1  transmitter ready
buffer_ready_o  out  1  start qualifier to transmitter
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse when playback ends (normal or stop)
sample_cnt_o  out  CNT_W  transfers accepted since the last start; saturating

Behaviour:
- Clock is clk_i. Reset is synchronous and active-high on rst_i. Reset mid-operation behaves like stop, but with no done_o pulse.
- Reset values: all outputs 0; state IDLE; FIFO empty; pointers 0.
- States:
  - IDLE -> PREFETCH on start_i with length_i != 0. This latches base, length and loop; clears offset, issued count and sample_cnt_o. start_i with length_i == 0 is ignored.
  - PREFETCH -> RUN when the FIFO is full (2 entries), or holds all samples when length == 1.
  - RUN -> DRAIN when all length reads are issued and loop == 0.
  - DRAIN -> IDLE when the FIFO is empty and no read is in flight; pulses done_o in the transition cycle.
  - Any non-IDLE state -> IDLE on stop_i. This flushes the FIFO, drops any in-flight read return, and pulses done_o.
- Command priority: stop_i beats start_i in the same cycle. start_i while busy is ignored.
- Reads:
  - rd_en_o is asserted in PREFETCH/RUN when (FIFO occupancy + in-flight) < 2 and reads remain (always true when looping).
  - rd_addr_o = base + offset, truncated to ADDR_W, so the window wraps past the top of RAM.
  - offset increments per read. In loop mode it returns to 0 after length-1.
  - Return data is pushed into the FIFO on the cycle after rd_en_o. A return is dropped if stop_i or reset occurred in between.
- Handshake:
  - tx_valid_o = FIFO non-empty AND state in {RUN, DRAIN}; tx_data_o = FIFO head.
  - A transfer occurs when tx_valid_o && tx_ready_i. It pops the head and increments sample_cnt_o, which saturates at all-ones.
  - tx_data_o stays stable while tx_valid_o is high and no transfer occurs.
  - FIFO push and pop in the same cycle, including when full, are legal and occupancy is unchanged.
- buffer_ready_o = state == RUN (level).
  - It drops in DRAIN, so the transmitter returns to its idle state at the next word-select edge after valid falls.
- Latency:
  - start_i to first rd_en_o: 1 cycle.
  - start_i to buffer_ready_o: 4 cycles (two reads, each returning 1 cycle later).

Optional Feature:
- Macro I2S_PLAYBACK_MONO_DUP_EN.
- Defined: each FIFO entry is presented twice (left then right slot) before being popped. An internal phase bit toggles per transfer, and sample_cnt_o counts transfers, so a length of N yields 2N transfers. The phase bit clears on start, stop and reset.
- Undefined: each entry is popped after a single transfer.

Decomposition:
- Shared package fpga_template_pkg holds:
  - the state typedef (IDLE, PREFETCH, RUN, DRAIN; 2 bits);
  - the FIFO depth constant (2);
  - DATA_W default 24.
- One natural sub-module: i2s_sample_fifo2, a 2-entry synchronous FIFO with push/pop/flush, full/empty and head output, flushed on stop.

Test Plan:
- RAM[i] = i+1, base 0, length 4, loop 0; tx_ready_i held high once RUN -> tx_data_o sequence 1, 2, 3, 4. Then buffer_ready_o falls, done_o pulses once and sample_cnt_o = 4.
- base 1022, length 4 -> rd_addr_o sequence 1022, 1023, 0, 1 (wrap-around).
- loop 1, length 3, 10 transfers -> data 1, 2, 3, 1, 2, 3, 1, 2, 3, 1. No done_o until stop_i; stop_i then flushes (tx_valid_o = 0 next cycle), done_o pulses once and busy_o = 0.
- start_i with length_i = 0 -> busy_o stays 0, no rd_en_o, no done_o. start_i and stop_i together in RUN -> IDLE, config unchanged.
- tx_ready_i asserted 1 cycle every 64, length 8 -> never more than 2 entries buffered, no sample skipped or duplicated. tx_data_o is stable while waiting.
- With I2S_PLAYBACK_MONO_DUP_EN, length 2 -> transfers 1, 1, 2, 2 and sample_cnt_o = 4. rst_i pulsed mid-RUN -> all outputs 0 next cycle, no done_o.

Source files
------------

// File: rtl/fpga_template_pkg.sv
// Shared state encoding and sizing constants for the I2S playback sequencer.
package fpga_template_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        RUN      = 2'd2,
        DRAIN    = 2'd3
    } play_state_e;

    localparam int FIFO_DEPTH = 2;
    localparam int DATA_W_DEF = 24;

endpackage

// File: rtl/i2s_sample_fifo2.sv
// Two-entry sample FIFO between RAM read returns and the I2S transmitter.
module i2s_sample_fifo2
    import fpga_template_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/i2s_playback_ctrl.sv
// Playback sequencer: walks a RAM window into a 2-entry buffer and feeds the I2S transmitter.
// Optional build macro I2S_PLAYBACK_MONO_DUP_EN presents each sample twice (left, right).
//
//   state    | meaning
//   IDLE     | waiting for start with a non-zero length
//   PREFETCH | filling the buffer before the transmitter is qualified
//   RUN      | streaming; buffer_ready_o high, reads keep the buffer topped up
//   DRAIN    | all reads issued, emptying the buffer before reporting done
module i2s_playback_ctrl
    import fpga_template_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   length_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              buffer_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  sample_cnt_o
);

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    play_state_e       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              loop_q, loop_d;
    logic [ADDR_W:0]   offset_q, offset_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              busy, tx_valid, xfer, pop, push, rd_en, flush, done;
    logic              start_acc, reads_left;
    logic [2:0]        count_next;
    logic [DATA_W-1:0] fifo_head;
    logic [1:0]        fifo_cnt;
    logic              fifo_full, fifo_empty;

`ifdef I2S_PLAYBACK_MONO_DUP_EN
    logic phase_q, phase_d;
`endif

    i2s_sample_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (rd_data_i),
        .head_o  (fifo_head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        loop_d     = loop_q;
        offset_d   = offset_q;
        issued_d   = issued_q;
        cnt_d      = cnt_q;
        inflight_d = 1'b0;
        flush      = 1'b0;
        done       = 1'b0;

        busy     = (state_q != IDLE);
        tx_valid = !fifo_empty && ((state_q == RUN) || (state_q == DRAIN));
        xfer     = tx_valid && tx_ready_i;
`ifdef I2S_PLAYBACK_MONO_DUP_EN
        phase_d = phase_q;
        pop     = xfer && phase_q;
        if (xfer) phase_d = ~phase_q;
`else
        pop = xfer;
`endif
        push       = inflight_q;
        reads_left = loop_q || (issued_q < len_q);
        // Buffered plus in-flight must stay below the FIFO depth.
        rd_en = ((state_q == PREFETCH) || (state_q == RUN)) && reads_left &&
                !fifo_full && !((fifo_cnt == 2'd1) && inflight_q);
        start_acc  = (state_q == IDLE) && start_i && !stop_i && (length_i != '0);
        count_next = {1'b0, fifo_cnt} + {2'b0, push} - {2'b0, pop};

        if (xfer && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

        if (rd_en) begin
            inflight_d = 1'b1;
            if (loop_q && (offset_q == len_q - ONE)) offset_d = '0;
            else                                      offset_d = offset_q + ONE;
            if (!loop_q) issued_d = issued_q + ONE;
        end

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d  = PREFETCH;
                    base_d   = base_addr_i;
                    len_d    = length_i;
                    loop_d   = loop_i;
                    offset_d = '0;
                    issued_d = '0;
                    cnt_d    = '0;
                end
            end
            PREFETCH: begin
                // Look at next-cycle occupancy so RUN begins as the buffer fills.
                if ((count_next == 3'd2) || ({{(ADDR_W-2){1'b0}}, count_next} == len_q))
                    state_d = RUN;
            end
            RUN: begin
                if (!loop_q && (issued_q == len_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty && !inflight_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop_i && busy) begin
            state_d    = IDLE;
            flush      = 1'b1;
            inflight_d = 1'b0;
            done       = 1'b1;
`ifdef I2S_PLAYBACK_MONO_DUP_EN
            phase_d    = 1'b0;
`endif
        end
`ifdef I2S_PLAYBACK_MONO_DUP_EN
        if (start_acc) phase_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            offset_q   <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            offset_q   <= offset_d;
            issued_q   <= issued_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef I2S_PLAYBACK_MONO_DUP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) phase_q <= 1'b0;
        else       phase_q <= phase_d;
    end
`endif

    assign rd_en_o        = rd_en;
    assign rd_addr_o      = base_q + offset_q[ADDR_W-1:0];
    assign tx_data_o      = fifo_head;
    assign tx_valid_o     = tx_valid;
    assign buffer_ready_o = (state_q == RUN);
    assign busy_o         = busy;
    assign done_o         = done && !rst_i;
    assign sample_cnt_o   = cnt_q;

endmodule
